dct_rot_coeff_gen: RTL and testbench
====================================

DCT_ROT_COEFF_GEN -- requirements
Module: dct_rot_coeff_gen

Interface
REQ-001 Parameter W_DATA, default 18: signed coefficient width; unity scale is 2^(W_DATA-2).
REQ-002 Parameter LOG2_NMAX, default 11: largest transform size NMAX = 2^LOG2_NMAX.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n_sync  in  1  synchronous reset, active low.
REQ-005 sink_valid  in  1  request one coefficient pair this cycle.
REQ-006 sink_sop  in  1  first request of a frame; qualified by sink_valid.
REQ-007 fftpts_in  in  LOG2_NMAX+1  transform size N; sampled only on sink_valid&&sink_sop.
REQ-008 mode  in  1  0 = IDCT rotation, 1 = forward DCT rotation; present only with DCTROT_DCT_MODE_EN.
REQ-009 source_valid, source_sop, source_eop  out  1 each  output qualifiers.
REQ-010 source_cos, source_sin  out  W_DATA each  signed coefficients.
REQ-011 source_k  out  LOG2_NMAX  index k (0-based) of the current output.
REQ-012 cfg_err  out  1  one-cycle pulse on an illegal fftpts_in at sop.

Function
REQ-013 Legal N: powers of two from 32 to NMAX inclusive; step = NMAX/N.
REQ-014 Output for k=0: cos = round(sqrt(2)*2^(W_DATA-2)), sin = 0 (W_DATA=18: 92682, 0).
REQ-015 Output for k=1..N-1: idx = k*step; cos = round(2^(W_DATA-2)*cos(pi*idx/(2*NMAX))); sin = round(2^(W_DATA-2)*sin(pi*idx/(2*NMAX))).
REQ-016 Coefficients come from one sine table over idx 0..NMAX; cos reads entry NMAX-idx.
REQ-017 FSM states: IDLE and RUN. IDLE->RUN on sink_valid&&sink_sop with legal N. RUN->IDLE on the accepted request with k=N-1.
REQ-018 In RUN, each sink_valid advances k by 1; cycles without sink_valid hold k, and the frame continues.
REQ-019 sink_valid without sink_sop in IDLE is ignored and produces no output.
REQ-020 sink_sop during RUN aborts the current frame, re-samples N and restarts at k=0; no eop is emitted for the aborted frame.
REQ-021 Illegal N at sop: pulse cfg_err 2 cycles later, stay in or return to IDLE, and emit no source_valid.
REQ-022 Latency: exactly 2 cycles from an accepted request to source_valid and its data; outputs are registered.
REQ-023 source_sop is asserted with k=0; source_eop is asserted with k=N-1; for N=32 the frame is 32 valid cycles.
REQ-024 source_k wraps to 0 only via eop or sop, never by overflow.

Reset
REQ-025 While rst_n_sync=0: FSM=IDLE, k=0, and source_valid/sop/eop, cfg_err, source_cos, source_sin and source_k are all 0.
REQ-026 Reset mid-frame discards the frame and any in-flight pipeline data; the first cycle after release outputs nothing.

Configuration
REQ-027 With DCTROT_DCT_MODE_EN defined: the mode port exists and is sampled at sop. When mode=1, source_sin is the two's-complement negation of REQ-015 (k=0 is still 0), and cos is unchanged.
REQ-028 Without DCTROT_DCT_MODE_EN: the mode port is absent and the block behaves as mode=0.

Structure
REQ-029 Package dct_rot_pkg holds: the FSM state typedef, MIN_LOG2_N=5, the sqrt(2) constant function, and a sine-table init function.
REQ-030 Sub-module dct_rot_sin_rom: dual-read-port registered ROM with NMAX+1 entries of W_DATA bits.

Verification
REQ-031 N=2048, 2048 back-to-back requests -> k=1 gives cos=65536, sin=50; eop on the 2048th output; then IDLE.
REQ-032 N=32 -> k=1 gives cos=65457, sin=3216; k=16 gives cos=46341, sin=46341; k=0 gives 92682, 0.
REQ-033 N=256 with sink_valid toggling 1/0 -> 256 outputs with monotonic k and no repeats; sop/eop correct.
REQ-034 sop with N=64 at k=10 of an N=512 frame -> next output k=0 using step 32, and no eop for the aborted frame.
REQ-035 fftpts_in=48 at sop -> cfg_err pulse 2 cycles later and no source_valid; a following legal sop works normally.
REQ-036 DCTROT_DCT_MODE_EN with mode=1, N=32, k=1 -> sin=-3216; reset asserted mid-frame -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/dct_rot_pkg.sv
// Shared types and elaboration-time helpers for the DCT rotation coefficient generator.
// The sine table is built by constant functions, so no external memory image is needed.
package dct_rot_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_LOG2_N = 5;

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        for (int i = 0; i < e; i++) begin
            r = r * 2.0;
        end
        return r;
    endfunction

    function automatic int sqrt2_scaled(input int w);
        return $rtoi(1.4142135623730951 * pow2(w - 2) + 0.5);
    endfunction

    // Odd Taylor series; the argument never exceeds pi/2, so 14 terms is far below one LSB.
    function automatic int sin_entry(input int idx, input int log2_nmax, input int w);
        real x;
        real term;
        real acc;
        x    = 3.141592653589793 * idx / pow2(log2_nmax + 1);
        term = x;
        acc  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / ((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi(acc * pow2(w - 2) + 0.5);
    endfunction

endpackage

// File: rtl/dct_rot_sin_rom.sv
// Quarter-wave sine table, NMAX+1 entries, with two independently addressed registered reads.
import dct_rot_pkg::*;

module dct_rot_sin_rom #(
    parameter int W_DATA    = 18,
    parameter int LOG2_NMAX = 11
) (
    input  logic                     clk,
    input  logic [LOG2_NMAX:0]       addr_a,
    input  logic [LOG2_NMAX:0]       addr_b,
    output logic signed [W_DATA-1:0] rd_a,
    output logic signed [W_DATA-1:0] rd_b
);

    localparam int NMAX = 1 << LOG2_NMAX;

    logic signed [W_DATA-1:0] table_c [0:NMAX];

    for (genvar i = 0; i <= NMAX; i++) begin : g_tab
        assign table_c[i] = W_DATA'(sin_entry(i, LOG2_NMAX, W_DATA));
    end

    always_ff @(posedge clk) begin
        rd_a <= table_c[addr_a];
        rd_b <= table_c[addr_b];
    end

endmodule

// File: rtl/dct_rot_coeff_gen.sv
// Per-request cos/sin rotation coefficient generator for N-point DCT/IDCT, two-cycle latency.
// Optional macro DCTROT_DCT_MODE_EN adds the mode port (forward DCT negates sin).
import dct_rot_pkg::*;

module dct_rot_coeff_gen #(
    parameter int W_DATA    = 18,
    parameter int LOG2_NMAX = 11
) (
    input  logic                     clk,
    input  logic                     rst_n_sync,
    input  logic                     sink_valid,
    input  logic                     sink_sop,
    input  logic [LOG2_NMAX:0]       fftpts_in,
`ifdef DCTROT_DCT_MODE_EN
    input  logic                     mode,
`endif
    output logic                     source_valid,
    output logic                     source_sop,
    output logic                     source_eop,
    output logic signed [W_DATA-1:0] source_cos,
    output logic signed [W_DATA-1:0] source_sin,
    output logic [LOG2_NMAX-1:0]     source_k,
    output logic                     cfg_err
);

    localparam int AW   = LOG2_NMAX + 1;
    localparam int LW   = $clog2(LOG2_NMAX + 1);
    localparam int NMAX = 1 << LOG2_NMAX;
    localparam logic signed [W_DATA-1:0] SQRT2 = W_DATA'(sqrt2_scaled(W_DATA));

    function automatic logic signed [W_DATA-1:0] apply_sign(input logic signed [W_DATA-1:0] v,
                                                            input logic neg);
        return neg ? -v : v;
    endfunction

    state_t                   state, state_nx;
    logic [LOG2_NMAX-1:0]     k_q, k_nx, k_cur, last_k_q;
    logic [LW-1:0]            n_log2_q, n_log2_nx, n_log2_in, n_log2_cur;
    logic                     mode_q, mode_nx, mode_in, mode_cur;
    logic                     legal, req, eop_cur, err;
    logic [AW-1:0]            idx, addr_cos;
    logic signed [W_DATA-1:0] rom_sin, rom_cos;
    logic                     vld_p0, sop_p0, eop_p0, err_p0, mode_p0;
    logic [LOG2_NMAX-1:0]     k_p0;

`ifdef DCTROT_DCT_MODE_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    always_comb begin
        n_log2_in = '0;
        for (int i = 0; i <= LOG2_NMAX; i++) begin
            if (fftpts_in[i]) n_log2_in = LW'(i);
        end
        legal = $onehot(fftpts_in) && (n_log2_in >= LW'(MIN_LOG2_N));
    end

    assign last_k_q = ~({LOG2_NMAX{1'b1}} << n_log2_q);

    always_comb begin
        state_nx   = state;
        k_nx       = k_q;
        n_log2_nx  = n_log2_q;
        mode_nx    = mode_q;
        k_cur      = k_q;
        n_log2_cur = n_log2_q;
        mode_cur   = mode_q;
        req        = 1'b0;
        eop_cur    = 1'b0;
        err        = 1'b0;
        if (sink_valid && sink_sop) begin
            if (legal) begin
                req        = 1'b1;
                k_cur      = '0;
                n_log2_cur = n_log2_in;
                mode_cur   = mode_in;
                n_log2_nx  = n_log2_in;
                mode_nx    = mode_in;
                k_nx       = LOG2_NMAX'(1);
                state_nx   = RUN;
            end else begin
                err      = 1'b1;
                k_nx     = '0;
                state_nx = IDLE;
            end
        end else if (sink_valid && state == RUN) begin
            req = 1'b1;
            if (k_q == last_k_q) begin
                eop_cur  = 1'b1;
                k_nx     = '0;
                state_nx = IDLE;
            end else begin
                k_nx = k_q + LOG2_NMAX'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            state    <= IDLE;
            k_q      <= '0;
            n_log2_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            k_q      <= k_nx;
            n_log2_q <= n_log2_nx;
            mode_q   <= mode_nx;
        end
    end

    assign idx      = AW'(k_cur) << (LOG2_NMAX - int'(n_log2_cur));
    assign addr_cos = AW'(NMAX) - idx;

    // Stage p0: table read registered inside the ROM, qualifiers alongside
    dct_rot_sin_rom #(
        .W_DATA   (W_DATA),
        .LOG2_NMAX(LOG2_NMAX)
    ) u_rom (
        .clk   (clk),
        .addr_a(idx),
        .addr_b(addr_cos),
        .rd_a  (rom_sin),
        .rd_b  (rom_cos)
    );

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            vld_p0 <= 1'b0;
            sop_p0 <= 1'b0;
            eop_p0 <= 1'b0;
            err_p0 <= 1'b0;
        end else begin
            vld_p0 <= req;
            sop_p0 <= req && sink_sop;
            eop_p0 <= eop_cur;
            err_p0 <= err;
        end
    end

    always_ff @(posedge clk) begin
        k_p0    <= k_cur;
        mode_p0 <= mode_cur;
    end

    // Stage p1: registered outputs; k=0 substitutes the sqrt(2) DC weight
    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            cfg_err      <= 1'b0;
            source_k     <= '0;
            source_cos   <= '0;
            source_sin   <= '0;
        end else begin
            source_valid <= vld_p0;
            source_sop   <= sop_p0;
            source_eop   <= eop_p0;
            cfg_err      <= err_p0;
            if (vld_p0) begin
                source_k   <= k_p0;
                source_cos <= (k_p0 == '0) ? SQRT2 : rom_cos;
                source_sin <= apply_sign(rom_sin, mode_p0);
            end
        end
    end

endmodule

// File: tb/tb_dct_rot_coeff_gen.sv
// Directed-plus-random bench for dct_rot_coeff_gen against a trigonometric reference model.
module tb_dct_rot_coeff_gen;

    localparam int    W_DATA    = 18;
    localparam int    LOG2_NMAX = 11;
    localparam int    NMAX      = 1 << LOG2_NMAX;
    localparam real   PI        = 3.141592653589793;
    localparam real   SCALE     = 65536.0;

    typedef struct {
        bit vld;
        bit sop;
        bit eop;
        bit err;
        int k;
        int cos_v;
        int sin_v;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n_sync = 1'b0;
    logic                     sink_valid = 1'b0;
    logic                     sink_sop = 1'b0;
    logic [LOG2_NMAX:0]       fftpts_in = '0;
`ifdef DCTROT_DCT_MODE_EN
    logic                     mode = 1'b0;
`endif
    logic                     source_valid, source_sop, source_eop, cfg_err;
    logic signed [W_DATA-1:0] source_cos, source_sin;
    logic [LOG2_NMAX-1:0]     source_k;

    int   checks = 0;
    int   errors = 0;
    bit   m_run = 0;
    int   m_n = 32;
    int   m_k = 0;
    bit   m_mode = 0;
    exp_t prev;
    int   seen_cos [0:NMAX-1];
    int   seen_sin [0:NMAX-1];

    dct_rot_coeff_gen #(.W_DATA(W_DATA), .LOG2_NMAX(LOG2_NMAX)) dut (
        .clk         (clk),
        .rst_n_sync  (rst_n_sync),
        .sink_valid  (sink_valid),
        .sink_sop    (sink_sop),
        .fftpts_in   (fftpts_in),
`ifdef DCTROT_DCT_MODE_EN
        .mode        (mode),
`endif
        .source_valid(source_valid),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .source_cos  (source_cos),
        .source_sin  (source_sin),
        .source_k    (source_k),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t none();
        exp_t e;
        e.vld = 0; e.sop = 0; e.eop = 0; e.err = 0;
        e.k = 0; e.cos_v = 0; e.sin_v = 0;
        return e;
    endfunction

    function automatic int rnd(input real x);
        return int'($floor(x + 0.5));
    endfunction

    function automatic exp_t emit(input int k, input int n, input bit neg);
        exp_t e;
        real  th;
        e     = none();
        e.vld = 1;
        e.sop = (k == 0);
        e.eop = (k == n - 1);
        e.k   = k;
        th    = PI * real'(k * (NMAX / n)) / (2.0 * NMAX);
        if (k == 0) begin
            e.cos_v = rnd($sqrt(2.0) * SCALE);
            e.sin_v = 0;
        end else begin
            e.cos_v = rnd(SCALE * $cos(th));
            e.sin_v = neg ? -rnd(SCALE * $sin(th)) : rnd(SCALE * $sin(th));
        end
        return e;
    endfunction

    task automatic model(input bit v, input bit s, input int n, input bit m, output exp_t e);
        e = none();
        if (v && s) begin
            if (n >= 32 && n <= NMAX && (n & (n - 1)) == 0) begin
                m_run = 1; m_n = n; m_k = 0;
`ifdef DCTROT_DCT_MODE_EN
                m_mode = m;
`else
                m_mode = 0;
`endif
            end else begin
                m_run = 0;
                e.err = 1;
            end
        end
        if (v && m_run) begin
            e = emit(m_k, m_n, m_mode);
            if (m_k == m_n - 1) begin
                m_run = 0;
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic compare(input exp_t e);
        check("valid", source_valid, e.vld);
        check("sop", source_sop, e.sop);
        check("eop", source_eop, e.eop);
        check("cfg_err", cfg_err, e.err);
        if (e.vld) begin
            check("k", source_k, e.k);
            check("cos", source_cos, e.cos_v);
            check("sin", source_sin, e.sin_v);
        end
        if (source_valid === 1'b1) begin
            seen_cos[source_k] = source_cos;
            seen_sin[source_k] = source_sin;
        end
    endtask

    task automatic step(input bit v, input bit s, input int n, input bit m);
        exp_t e;
        sink_valid = v;
        sink_sop   = s;
        fftpts_in  = n[LOG2_NMAX:0];
`ifdef DCTROT_DCT_MODE_EN
        mode = m;
`endif
        model(v, s, n, m, e);
        @(posedge clk); #1;
        compare(prev);
        prev = e;
    endtask

    task automatic rst_step(input bit v, input bit s);
        rst_n_sync = 1'b0;
        sink_valid = v;
        sink_sop   = s;
        fftpts_in  = 12'd64;
        @(posedge clk); #1;
        check("rst_valid", source_valid, 0);
        check("rst_sop", source_sop, 0);
        check("rst_eop", source_eop, 0);
        check("rst_err", cfg_err, 0);
        check("rst_k", source_k, 0);
        check("rst_cos", source_cos, 0);
        check("rst_sin", source_sin, 0);
        m_run = 0; m_k = 0;
        prev = none();
        rst_n_sync = 1'b1;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NMAX; i++) begin
            seen_cos[i] = -999999;
            seen_sin[i] = -999999;
        end
    endtask

    task automatic frame(input int n, input bit m);
        step(1, 1, n, m);
        for (int i = 1; i < n; i++) step(1, 0, n, m);
        step(0, 0, n, m);
        step(0, 0, n, m);
    endtask

    initial begin
        prev = none();
        clear_seen();
        rst_step(1, 1);
        rst_step(0, 0);
        step(0, 0, 32, 0);
        step(1, 0, 32, 0);
        step(1, 0, 32, 0);
        step(0, 0, 32, 0);

        clear_seen();
        frame(32, 0);
        check("n32_k0_cos", seen_cos[0], 92682);
        check("n32_k0_sin", seen_sin[0], 0);
        check("n32_k1_cos", seen_cos[1], 65457);
        check("n32_k1_sin", seen_sin[1], 3216);
        check("n32_k16_cos", seen_cos[16], 46341);
        check("n32_k16_sin", seen_sin[16], 46341);

        clear_seen();
        frame(2048, 0);
        check("n2048_k1_cos", seen_cos[1], 65536);
        check("n2048_k1_sin", seen_sin[1], 50);
        for (int i = 0; i < 4; i++) step(1, 0, 2048, 0);

        step(1, 1, 256, 0);
        for (int i = 0; i < 520; i++) step(i % 2 == 1, 0, 256, 0);

        step(1, 1, 512, 0);
        for (int i = 1; i <= 10; i++) step(1, 0, 512, 0);
        step(1, 1, 64, 0);
        for (int i = 0; i < 70; i++) step(1, 0, 64, 0);

        step(1, 1, 48, 0);
        step(0, 0, 48, 0);
        step(0, 0, 48, 0);
        step(1, 0, 48, 0);
        step(1, 1, 128, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 128, 0);
        step(1, 1, 16, 0);
        step(1, 0, 16, 0);
        step(1, 1, 3000, 0);
        step(1, 1, 0, 0);
        frame(32, 0);

        step(1, 1, 1024, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 1024, 0);
        rst_step(1, 0);
        step(1, 0, 1024, 0);
        step(1, 0, 1024, 0);
        frame(64, 0);

`ifdef DCTROT_DCT_MODE_EN
        clear_seen();
        frame(32, 1);
        check("dct_k1_sin", seen_sin[1], -3216);
        check("dct_k1_cos", seen_cos[1], 65457);
        check("dct_k0_sin", seen_sin[0], 0);
`endif

        for (int f = 0; f < 6; f++) begin
            int  n;
            bit  m;
            n = 32 << $urandom_range(0, 3);
            m = 1'($urandom_range(0, 1));
            step(1, 1, n, m);
            for (int i = 0; i < 2 * n; i++) begin
                bit v;
                bit s;
                v = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 99) == 0);
                if (s) step(v, s, ($urandom_range(0, 4) == 0) ? 96 : (32 << $urandom_range(0, 3)), m);
                else   step(v, s, n, m);
            end
        end
        step(0, 0, 32, 0);
        step(0, 0, 32, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
